debounce_multi_fsmd: RTL and testbench
======================================

# debounce_multi_fsmd

Parametrised multi-channel switch debouncer built as one four-state FSMD per channel, with a shared count width and reload value. Each channel emits a debounced level plus single-cycle rising-edge and falling-edge ticks. It sits between raw board inputs (switches, push-buttons) and the synchronous control logic. It supersedes single-channel debouncers that have a fixed count and a rising tick only.

## Interface
- `CH`, default 4: number of independent channels, ≥1.
- `CNT_W`, default 21: width of each channel's down-counter.
- `LOAD`, default 2**CNT_W-1: reload value; a level must stay stable for this many cycles. Legal range is 1 to 2**CNT_W-1.

- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-high; takes effect on the next rising `clk` edge.
- `sw` input, CH bits: raw switch inputs, one bit per channel.
- `db_level` output, CH bits: debounced level per channel, registered.
- `db_rise` output, CH bits: one-cycle pulse when a channel's level goes 0→1, registered.
- `db_fall` output, CH bits: one-cycle pulse when a channel's level goes 1→0, registered.

## Operation
- Each channel has states ZERO, WAIT1, ONE and WAIT0, plus a CNT_W-bit down-counter. Channels share no state.
- In the rules below, `s` is the channel's sampled input: raw `sw[i]`, or its synchronised copy (see Configuration).
- ZERO:
  - `s`=1 → WAIT1 and load count = LOAD.
  - Otherwise stay in ZERO.
- WAIT1:
  - `s`=0 → ZERO; count is held.
  - `s`=1 and count>1 → decrement count.
  - `s`=1 and count==1 → ONE, count←0, and pulse `db_rise`.
- ONE:
  - `s`=0 → WAIT0 and load count = LOAD.
  - Otherwise stay in ONE.
- WAIT0:
  - `s`=1 → ONE; count is held.
  - `s`=0 and count>1 → decrement count.
  - `s`=0 and count==1 → ZERO, count←0, and pulse `db_fall`.
- `db_level[i]` is 1 exactly when the state is ONE or WAIT0. A glitch during WAIT0 therefore never drops the level.
- Ticks occur only on completed transitions. An aborted wait (WAIT1→ZERO or WAIT0→ONE) produces no tick and no change in level.
- Count arithmetic is unsigned CNT_W bits. The counter never decrements below 1 within a wait state, so wrap-around cannot occur.
- `db_rise` and `db_fall` are never both high on the same channel in the same cycle.

## Timing
- Reset values: every state is ZERO, every count is 0, and `db_level`, `db_rise` and `db_fall` are all zeros. Synchroniser flops, when present, are also cleared.
- Reset mid-wait: the channel returns to ZERO at the next edge and no tick is emitted. Reset takes priority over every transition.
- Latency, rising: `s` goes 1 and is sampled in ZERO at edge E0.
  - The state is WAIT1 after E0 and stays there for LOAD cycles.
  - `db_level`=1 and `db_rise`=1 in the cycle after edge E0+LOAD; `db_rise` lasts exactly one cycle.
  - Total is LOAD+1 cycles from the sample edge.
- Latency, falling: symmetric, with `db_fall`.
- A bounce on any cycle of a wait aborts it. The next stable run restarts the full LOAD count.
- Minimum LOAD=1 gives a 2-cycle filter. LOAD=0 is illegal; the implementation adds an elaboration-time check (`$error` in a generate block).

## Configuration
- `DEBOUNCE_SYNC_EN` defined: each `sw[i]` passes through a 2-flop synchroniser before the FSM. All latencies increase by 2 cycles. The synchroniser flops reset to 0.
- `DEBOUNCE_SYNC_EN` undefined: the FSM samples `sw` directly. The caller guarantees `sw` is already synchronous to `clk`.

## Test plan
The bench uses CH=2, CNT_W=3, LOAD=5. The first five scenarios run with `DEBOUNCE_SYNC_EN` undefined.
- Clean rise: `sw[0]` held at 1 from cycle 0 → `db_level[0]`=1 and `db_rise[0]`=1 at cycle 6 only; `sw[1]` unaffected, so all channel-1 outputs stay 0.
- Bounce abort: `sw[0]` high for 3 cycles, low for 1, then high continuously → no tick until 6 cycles after the final rise.
- Clean fall with glitch: from ONE, drop `sw[0]` and then pulse it high 2 cycles later → WAIT0 aborts to ONE with `db_level` held at 1 and no `db_fall`. A later 6-cycle-stable low gives `db_fall`=1 for one cycle and `db_level`=0.
- Independent channels: both channels rise together and `sw[1]` bounces once → `db_rise[0]` at cycle 6 and `db_rise[1]` later; no cross-coupling.
- Reset mid-wait: assert `reset` while count=2 in WAIT1 → the next cycle shows ZERO with all outputs 0 and no tick. Releasing `reset` with `sw` still high restarts the full count.
- Synchroniser build: with `DEBOUNCE_SYNC_EN` defined, repeat the clean rise → `db_rise[0]` at cycle 8.

Source files
------------

// File: rtl/debounce_multi_fsmd_if.sv
// Signal bundle between raw switch inputs and the debouncer outputs.
// The slave side is the debouncer. state carries each channel's 2-bit FSM state for observation.
interface debounce_multi_fsmd_if #(
    parameter int CH = 4
);
    logic [CH-1:0]   sw;
    logic [CH-1:0]   db_level;
    logic [CH-1:0]   db_rise;
    logic [CH-1:0]   db_fall;
    logic [2*CH-1:0] state;

    modport master (
        output sw,
        input  db_level,
        input  db_rise,
        input  db_fall,
        input  state
    );

    modport slave (
        input  sw,
        output db_level,
        output db_rise,
        output db_fall,
        output state
    );
endinterface

// File: rtl/debounce_multi_fsmd.sv
// Multi-channel switch debouncer: one ZERO/WAIT1/ONE/WAIT0 FSMD per channel with level, rise and fall outputs.
// Optional macro DEBOUNCE_SYNC_EN inserts a 2-flop synchroniser in front of every channel.
module debounce_multi_fsmd #(
    parameter int CH    = 4,
    parameter int CNT_W = 21,
    parameter int LOAD  = 2**CNT_W - 1
) (
    input logic                  clk,
    input logic                  reset,
    debounce_multi_fsmd_if.slave bus
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD);
    localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

    if (LOAD < 1 || LOAD > 2**CNT_W - 1) begin : g_bad_load
        $error("debounce_multi_fsmd: LOAD must be in 1 .. 2**CNT_W-1");
    end
    if (CH < 1) begin : g_bad_ch
        $error("debounce_multi_fsmd: CH must be at least 1");
    end

    logic [CH-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
    logic [CH-1:0] sync1;
    logic [CH-1:0] sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.sw;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = bus.sw;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             rise_q;
        logic             rise_d;
        logic             fall_q;
        logic             fall_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ZERO;
                cnt_q   <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // An aborted wait keeps the count; it is reloaded on the next entry anyway.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                ZERO: begin
                    if (s[i]) begin
                        state_d = WAIT1;
                        cnt_d   = LOAD_V;
                    end
                end
                WAIT1: begin
                    if (!s[i]) begin
                        state_d = ZERO;
                    end else if (cnt_q == ONE_V) begin
                        state_d = ONE;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE_V;
                    end
                end
                ONE: begin
                    if (!s[i]) begin
                        state_d = WAIT0;
                        cnt_d   = LOAD_V;
                    end
                end
                WAIT0: begin
                    if (s[i]) begin
                        state_d = ONE;
                    end else if (cnt_q == ONE_V) begin
                        state_d = ZERO;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE_V;
                    end
                end
                default: begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end
            endcase
        end

        assign bus.db_level[i]     = (state_q == ONE) || (state_q == WAIT0);
        assign bus.db_rise[i]      = rise_q;
        assign bus.db_fall[i]      = fall_q;
        assign bus.state[2*i +: 2] = state_q;
    end

endmodule

// File: tb/tb_debounce_multi_fsmd.sv
// Bench for debounce_multi_fsmd: a run-length model checked every cycle plus literal cycle expectations.
// Define DEBOUNCE_SYNC_EN for both bench and RTL to exercise the synchroniser build.
module tb_debounce_multi_fsmd;
  localparam int CH    = 2;
  localparam int CNT_W = 3;
  localparam int LOAD  = 5;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  typedef struct {
    int            at;
    logic [CH-1:0] lv;
    logic [CH-1:0] rs;
    logic [CH-1:0] fl;
    string         nm;
  } lit_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  debounce_multi_fsmd_if #(.CH(CH)) bus ();

  debounce_multi_fsmd #(
    .CH    (CH),
    .CNT_W (CNT_W),
    .LOAD  (LOAD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  lit_t lit_q[$];

  // Model: a channel flips once it has seen LOAD+1 consecutive samples that differ from its level.
  int            cyc = 0;
  logic [CH-1:0] m_level = '0;
  logic [CH-1:0] m_rise = '0;
  logic [CH-1:0] m_fall = '0;
  logic [CH-1:0] hist1 = '0;
  logic [CH-1:0] hist2 = '0;
  int            run[CH];

  always @(posedge clk) begin
    logic [CH-1:0] smp;
    cyc++;
    if (reset) begin
      m_level = '0;
      m_rise = '0;
      m_fall = '0;
      hist1 = '0;
      hist2 = '0;
      for (int c = 0; c < CH; c++) run[c] = 0;
    end else begin
`ifdef DEBOUNCE_SYNC_EN
      smp = hist2;
      hist2 = hist1;
      hist1 = bus.sw;
`else
      smp = bus.sw;
`endif
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < CH; c++) begin
        if (smp[c] != m_level[c]) begin
          run[c]++;
          if (run[c] == LOAD + 1) begin
            m_level[c] = smp[c];
            if (smp[c]) m_rise[c] = 1'b1;
            else m_fall[c] = 1'b1;
            run[c] = 0;
          end
        end else begin
          run[c] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    lit_t e;
    if (cyc > 0) begin
      n_checks++;
      if (bus.db_level !== m_level) begin
        n_fail++;
        $display("FAIL level cyc=%0d got=%b exp=%b", cyc, bus.db_level, m_level);
      end
      n_checks++;
      if (bus.db_rise !== m_rise) begin
        n_fail++;
        $display("FAIL rise cyc=%0d got=%b exp=%b", cyc, bus.db_rise, m_rise);
      end
      n_checks++;
      if (bus.db_fall !== m_fall) begin
        n_fail++;
        $display("FAIL fall cyc=%0d got=%b exp=%b", cyc, bus.db_fall, m_fall);
      end
      n_checks++;
      if ((bus.db_rise & bus.db_fall) != '0) begin
        n_fail++;
        $display("FAIL rise_fall_exclusive cyc=%0d rise=%b fall=%b", cyc, bus.db_rise, bus.db_fall);
      end
      while (lit_q.size() > 0 && lit_q[0].at <= cyc) begin
        e = lit_q.pop_front();
        n_checks++;
        if (e.at != cyc || bus.db_level !== e.lv || bus.db_rise !== e.rs || bus.db_fall !== e.fl) begin
          n_fail++;
          $display("FAIL %s cyc=%0d(want %0d) got lvl/rise/fall=%b/%b/%b exp=%b/%b/%b",
                   e.nm, cyc, e.at, bus.db_level, bus.db_rise, bus.db_fall, e.lv, e.rs, e.fl);
        end
        n_checks++;
        if (m_level !== e.lv || m_rise !== e.rs || m_fall !== e.fl) begin
          n_fail++;
          $display("FAIL model_%s cyc=%0d model lvl/rise/fall=%b/%b/%b exp=%b/%b/%b",
                   e.nm, cyc, m_level, m_rise, m_fall, e.lv, e.rs, e.fl);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int at, input logic [CH-1:0] lv, input logic [CH-1:0] rs,
                           input logic [CH-1:0] fl, input string nm);
    lit_t e;
    e.at = at;
    e.lv = lv;
    e.rs = rs;
    e.fl = fl;
    e.nm = nm;
    lit_q.push_back(e);
  endtask

  initial begin
    int c;
    int r;
    bus.sw = '0;
    reset = 1'b1;
    step(2);
    expect_at(cyc + 1, 2'b00, 2'b00, 2'b00, "reset_state");
    step(1);
    reset = 1'b0;
    step(2);

    // Clean rise on channel 0
    c = cyc;
    bus.sw = 2'b01;
    expect_at(c + 5 + SD, 2'b00, 2'b00, 2'b00, "rise_early");
    expect_at(c + 6 + SD, 2'b01, 2'b01, 2'b00, "rise_tick");
    expect_at(c + 7 + SD, 2'b01, 2'b00, 2'b00, "rise_one_cycle");
    step(12);

    // Fall with a glitch two cycles in, then a clean stable low
    c = cyc;
    bus.sw = 2'b00;
    step(2);
    expect_at(c + 3 + SD, 2'b01, 2'b00, 2'b00, "glitch_hold");
    bus.sw = 2'b01;
    step(1);
    bus.sw = 2'b00;
    expect_at(c + 8 + SD, 2'b01, 2'b00, 2'b00, "fall_early");
    expect_at(c + 9 + SD, 2'b00, 2'b00, 2'b01, "fall_tick");
    expect_at(c + 10 + SD, 2'b00, 2'b00, 2'b00, "fall_one_cycle");
    step(12);

    // Bounce abort on a rise
    c = cyc;
    bus.sw = 2'b01;
    step(3);
    bus.sw = 2'b00;
    step(1);
    bus.sw = 2'b01;
    expect_at(c + 9 + SD, 2'b00, 2'b00, 2'b00, "bounce_no_tick");
    expect_at(c + 10 + SD, 2'b01, 2'b01, 2'b00, "bounce_tick");
    step(12);
    bus.sw = 2'b00;
    step(12);

    // Both channels rise, channel 1 bounces once
    c = cyc;
    bus.sw = 2'b11;
    step(2);
    bus.sw = 2'b01;
    step(1);
    bus.sw = 2'b11;
    expect_at(c + 6 + SD, 2'b01, 2'b01, 2'b00, "ind_rise0");
    expect_at(c + 9 + SD, 2'b11, 2'b10, 2'b00, "ind_rise1");
    step(12);
    bus.sw = 2'b00;
    step(12);

    // Reset while channel 0 sits in WAIT1 with count 2
    c = cyc;
    bus.sw = 2'b01;
    step(4 + SD);
    reset = 1'b1;
    r = cyc + 1;
    expect_at(r, 2'b00, 2'b00, 2'b00, "reset_midwait");
    step(1);
    reset = 1'b0;
    expect_at(r + 5 + SD, 2'b00, 2'b00, 2'b00, "restart_early");
    expect_at(r + 6 + SD, 2'b01, 2'b01, 2'b00, "restart_tick");
    step(12);
    bus.sw = 2'b00;
    step(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
